vend_sequencer: RTL and testbench

Multi-product vending controller that accumulates coin credit, validates product selection against price and stock, sequences the dispenser mechanism through a req/ack handshake, and pays change one 5-unit coin at a time through the coin hopper. It sits between the coin-slot front end and the dispenser/hopper actuators and is the sole owner of both actuators.

---
 rtl/vend_pkg.sv | 20 ++
 rtl/vend_sequencer_stock_counter.sv | 36 +++
 rtl/vend_sequencer.sv | 170 +++++++++++++++++
 tb/tb_vend_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending sequencer.
package vend_pkg;

    localparam int CREDIT_W = 6;
    localparam int STOCK_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    localparam logic [CREDIT_W-1:0] COIN5  = 6'd5;
    localparam logic [CREDIT_W-1:0] COIN10 = 6'd10;

    // Element 0 is product 0: prices 15, 20, 10, 25.
    localparam logic [3:0][CREDIT_W-1:0] PRICE = {6'd25, 6'd10, 6'd20, 6'd15};

endpackage

// File: rtl/vend_sequencer_stock_counter.sv
// Per-product stock counter: loads INIT_STOCK on reset, decrements on a
// successful dispense, saturates at zero and flags the empty condition.
module stock_counter
    import vend_pkg::*;
#(
    parameter int INIT_STOCK = 7
) (
    input  logic clk,
    input  logic rst,
    input  logic dec,
    output logic zero
);

    logic [STOCK_W-1:0] count_q;
    logic [STOCK_W-1:0] count_d;

    // Decrement when asked, never wrapping below zero.
    always_comb begin
        count_d = count_q;
        if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Stock register, reloaded whenever reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= STOCK_W'(INIT_STOCK);
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/vend_sequencer.sv
// Vending controller: coin credit accumulation, product selection check,
// dispenser req/ack sequencing and 5-unit change payout.
// Optional macro CANCEL_REFUND_EN adds a 'cancel' input that refunds all
// credit as change while in CREDIT.
module vend_sequencer
    import vend_pkg::*;
#(
    parameter int NPROD      = 4,
    parameter int MAX_CREDIT = 60,
    parameter int INIT_STOCK = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             coin_valid,
    input  logic             coin_val,
    input  logic             sel_valid,
    input  logic [1:0]       sel_id,
    input  logic             disp_ack,
    input  logic             chg_ack,
`ifdef CANCEL_REFUND_EN
    input  logic             cancel,
`endif
    output logic             disp_req,
    output logic [1:0]       disp_id,
    output logic             chg_req,
    output logic             coin_reject,
    output logic             sel_err,
    output logic [5:0]       credit,
    output logic             busy,
    output logic [NPROD-1:0] sold_out
);

    state_t              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [1:0]          disp_id_q, disp_id_d;
    logic                coin_reject_q, coin_reject_d;
    logic                sel_err_q, sel_err_d;

    logic [CREDIT_W-1:0] coin_amt;
    logic                coin_fits;
    logic [3:0]          sold_pad;
    logic                sel_ok;
    logic [CREDIT_W-1:0] price_sel;
    logic                dispense_done;
    logic                cancel_req;

`ifdef CANCEL_REFUND_EN
    assign cancel_req = cancel;
`else
    assign cancel_req = 1'b0;
`endif

    assign coin_amt  = coin_val ? COIN10 : COIN5;
    assign coin_fits = ({1'b0, credit_q} + {1'b0, coin_amt}) <= (CREDIT_W+1)'(MAX_CREDIT);
    // Padding to four bits keeps the sold_out lookup in range for NPROD < 4;
    // the range check on sel_id rejects those padded entries first.
    assign sold_pad  = 4'(sold_out);
    assign sel_ok    = (32'(sel_id) < NPROD) && !sold_pad[sel_id] &&
                       (credit_q >= PRICE[sel_id]);
    assign price_sel = PRICE[disp_id_q];
    assign dispense_done = (state_q == ST_DISPENSE) && disp_ack;

    // Next-state, credit and pulse-output decisions.
    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        disp_id_d     = disp_id_q;
        coin_reject_d = 1'b0;
        sel_err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    sel_err_d     = 1'b1;
                    coin_reject_d = coin_valid;
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d = credit_q + coin_amt;
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_CREDIT: begin
                if (sel_valid) begin
                    // A coin arriving with a selection is always returned.
                    coin_reject_d = coin_valid;
                    if (sel_ok) begin
                        disp_id_d = sel_id;
                        state_d   = ST_DISPENSE;
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end else if (cancel_req) begin
                    coin_reject_d = coin_valid;
                    state_d       = ST_CHANGE;
                end else if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d = credit_q + coin_amt;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                sel_err_d     = sel_valid;
                if (disp_ack) begin
                    credit_d = credit_q - price_sel;
                    state_d  = (credit_q != price_sel) ? ST_CHANGE : ST_IDLE;
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                sel_err_d     = sel_valid;
                if (chg_ack) begin
                    if (credit_q <= COIN5) begin
                        credit_d = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        credit_d = credit_q - COIN5;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            credit_q      <= '0;
            disp_id_q     <= '0;
            coin_reject_q <= 1'b0;
            sel_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            disp_id_q     <= disp_id_d;
            coin_reject_q <= coin_reject_d;
            sel_err_q     <= sel_err_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NPROD; gi++) begin : g_stock
            stock_counter #(
                .INIT_STOCK(INIT_STOCK)
            ) u_stock (
                .clk  (clk),
                .rst  (rst),
                .dec  (dispense_done && (disp_id_q == 2'(gi))),
                .zero (sold_out[gi])
            );
        end
    endgenerate

    assign disp_req    = (state_q == ST_DISPENSE);
    assign chg_req     = (state_q == ST_CHANGE);
    assign busy        = disp_req || chg_req;
    assign disp_id     = disp_id_q;
    assign credit      = credit_q;
    assign coin_reject = coin_reject_q;
    assign sel_err     = sel_err_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer: a cycle-by-cycle vector table plus
// hand-written sequences for ceiling, sell-out and reset-abort cases.
module tb_vend_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic       coin_val = 1'b0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel_id = 2'd0;
    logic       disp_ack = 1'b0;
    logic       chg_ack = 1'b0;
`ifdef CANCEL_REFUND_EN
    logic       cancel = 1'b0;
`endif
    logic       disp_req;
    logic [1:0] disp_id;
    logic       chg_req;
    logic       coin_reject;
    logic       sel_err;
    logic [5:0] credit;
    logic       busy;
    logic [3:0] sold_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    vend_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .sel_valid   (sel_valid),
        .sel_id      (sel_id),
        .disp_ack    (disp_ack),
        .chg_ack     (chg_ack),
`ifdef CANCEL_REFUND_EN
        .cancel      (cancel),
`endif
        .disp_req    (disp_req),
        .disp_id     (disp_id),
        .chg_req     (chg_req),
        .coin_reject (coin_reject),
        .sel_err     (sel_err),
        .credit      (credit),
        .busy        (busy),
        .sold_out    (sold_out)
    );

    typedef struct {
        logic       cv;
        logic       cval;
        logic       sv;
        logic [1:0] sid;
        logic       da;
        logic       ca;
        logic [5:0] cr;
        logic       dreq;
        logic [1:0] did;
        logic       creq;
        logic       rej;
        logic       serr;
        logic       bsy;
    } vec_t;

    vec_t vecs [24];

    function automatic vec_t v(input int cv, input int cval, input int sv, input int sid,
                               input int da, input int ca, input int cr, input int dreq,
                               input int did, input int creq, input int rej, input int serr,
                               input int bsy);
        vec_t r;
        r.cv = cv[0];   r.cval = cval[0]; r.sv = sv[0];     r.sid = sid[1:0];
        r.da = da[0];   r.ca = ca[0];     r.cr = cr[5:0];   r.dreq = dreq[0];
        r.did = did[1:0]; r.creq = creq[0]; r.rej = rej[0]; r.serr = serr[0];
        r.bsy = bsy[0];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Drive one cycle of inputs, sample outputs 1 time unit after the edge.
    task automatic step(input logic cv, input logic cval, input logic sv,
                        input logic [1:0] sid, input logic da, input logic ca);
        coin_valid = cv; coin_val = cval; sel_valid = sv; sel_id = sid;
        disp_ack = da; chg_ack = ca;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; coin_val = 1'b0; sel_valid = 1'b0; sel_id = 2'd0;
        disp_ack = 1'b0; chg_ack = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [5:0] cr, input logic dreq,
                              input logic creq, input logic rej, input logic serr,
                              input logic bsy);
        chk({tag, "_credit"}, 32'(credit), 32'(cr));
        chk({tag, "_disp_req"}, 32'(disp_req), 32'(dreq));
        chk({tag, "_chg_req"}, 32'(chg_req), 32'(creq));
        chk({tag, "_coin_reject"}, 32'(coin_reject), 32'(rej));
        chk({tag, "_sel_err"}, 32'(sel_err), 32'(serr));
        chk({tag, "_busy"}, 32'(busy), 32'(bsy));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        //            cv cval sv sid da ca  cr dreq did creq rej serr busy
        vecs[0]  = v(1, 1,  0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        vecs[1]  = v(1, 0,  0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0);
        vecs[2]  = v(0, 0,  1, 0, 0, 0, 15, 1, 0, 0, 0, 0, 1);
        vecs[3]  = v(0, 0,  1, 2, 0, 0, 15, 1, 0, 0, 0, 1, 1);
        vecs[4]  = v(1, 0,  0, 0, 0, 0, 15, 1, 0, 0, 1, 0, 1);
        vecs[5]  = v(0, 0,  0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[6]  = v(0, 0,  0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        vecs[7]  = v(0, 0,  1, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0);
        vecs[8]  = v(1, 1,  0, 0, 0, 0, 10, 0, 0, 0, 0, 0, 0);
        vecs[9]  = v(1, 1,  0, 0, 0, 0, 20, 0, 0, 0, 0, 0, 0);
        vecs[10] = v(1, 1,  0, 0, 0, 0, 30, 0, 0, 0, 0, 0, 0);
        vecs[11] = v(0, 0,  1, 1, 0, 0, 30, 1, 1, 0, 0, 0, 1);
        vecs[12] = v(0, 0,  0, 0, 1, 0, 10, 0, 0, 1, 0, 0, 1);
        vecs[13] = v(0, 0,  0, 0, 0, 1,  5, 0, 0, 1, 0, 0, 1);
        vecs[14] = v(0, 0,  0, 0, 0, 0,  5, 0, 0, 1, 0, 0, 1);
        vecs[15] = v(0, 0,  0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[16] = v(0, 0,  0, 0, 1, 1,  0, 0, 0, 0, 0, 0, 0);
        vecs[17] = v(1, 0,  0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0);
        vecs[18] = v(0, 0,  1, 3, 0, 0,  5, 0, 0, 0, 0, 1, 0);
        vecs[19] = v(0, 0,  0, 0, 0, 0,  5, 0, 0, 0, 0, 0, 0);
        vecs[20] = v(1, 1,  0, 0, 0, 0, 15, 0, 0, 0, 0, 0, 0);
        vecs[21] = v(1, 1,  0, 0, 0, 0, 25, 0, 0, 0, 0, 0, 0);
        vecs[22] = v(0, 0,  1, 3, 0, 0, 25, 1, 3, 0, 0, 0, 1);
        vecs[23] = v(0, 0,  0, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);

        // Reset state, sampled while reset is still held.
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset_disp_id", 32'(disp_id), 32'd0);
        chk("reset_sold_out", 32'(sold_out), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 24; i++) begin
            step(vecs[i].cv, vecs[i].cval, vecs[i].sv, vecs[i].sid, vecs[i].da, vecs[i].ca);
            expect_out($sformatf("vec%0d", i), vecs[i].cr, vecs[i].dreq, vecs[i].creq,
                       vecs[i].rej, vecs[i].serr, vecs[i].bsy);
            if (vecs[i].dreq)
                chk($sformatf("vec%0d_disp_id", i), 32'(disp_id), 32'(vecs[i].did));
            $display("vector %0d: credit=%0d disp_req=%0b chg_req=%0b", i, credit, disp_req, chg_req);
        end

        // Credit ceiling, then coin+selection in the same cycle, then long change.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("fill60", 6'd60, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("over5", 6'd60, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        expect_out("over10", 6'd60, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 2'd2, 1'b0, 1'b0);
        expect_out("coin_sel", 6'd60, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("coin_sel_disp_id", 32'(disp_id), 32'd2);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_out("ack60", 6'd50, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
            expect_out($sformatf("chg%0d", i), 6'(50 - 5 * i), 1'b0, (i < 10), 1'b0, 1'b0, (i < 10));
            $display("change coin %0d: credit=%0d chg_req=%0b", i, credit, chg_req);
        end

        // Sell out product 2 from a fresh stock of 7.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
            step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
            chk($sformatf("buy%0d_disp_req", i), 32'(disp_req), 32'd1);
            step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
            chk($sformatf("buy%0d_credit", i), 32'(credit), 32'd0);
            chk($sformatf("buy%0d_sold_out", i), 32'(sold_out), (i == 6) ? 32'h4 : 32'h0);
            $display("purchase %0d of product 2: sold_out=%b", i, sold_out);
        end
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0);
        expect_out("buy_empty", 6'd10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset asserted in CHANGE with 15 credit aborts immediately.
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0);
        expect_out("pre_abort", 6'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_out("abort", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("abort_sold_out", 32'(sold_out), 32'd0);
        $display("reset abort: credit=%0d chg_req=%0b sold_out=%b", credit, chg_req, sold_out);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;

`ifdef CANCEL_REFUND_EN
        // Cancel in IDLE is ignored; cancel in CREDIT refunds all credit.
        cancel = 1'b1;
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cancel = 1'b0;
        expect_out("cancel_idle", 6'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cancel = 1'b1;
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        cancel = 1'b0;
        expect_out("cancel", 6'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1);
            expect_out($sformatf("refund%0d", i), 6'(15 - 5 * i), 1'b0, (i < 3), 1'b0, 1'b0, (i < 3));
            $display("refund coin %0d: credit=%0d", i, credit);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
